game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start; range 1..3.
REQ-002 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before ball release; range 1..63.
REQ-003 Parameter MISS_FRAMES, default 63: frame ticks spent in MISS; range 1..63.
REQ-004 clk25  input  1  25 MHz pixel clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 xpos  input  10  current pixel column from the VGA timing block.
REQ-007 ypos  input  10  current pixel row from the VGA timing block.
REQ-008 start  input  1  raw pushbutton, asynchronous to clk25, active-high.
REQ-009 hit  input  1  one-cycle pulse from the datapath on a ball/paddle bounce.
REQ-010 miss  input  1  one-cycle pulse from the datapath when the ball reaches the bottom border.
REQ-011 ball_run  output  1  high = datapath may advance the ball this frame.
REQ-012 ball_serve  output  1  one-cycle pulse; datapath reloads the ball to the serve position.
REQ-013 score  output  8  two BCD digits, [7:4] tens, [3:0] units.
REQ-014 lives  output  2  remaining lives.
REQ-015 state  output  3  FSM encoding: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-016 flash  output  1  high = video overlays the miss/game-over colour.

Function
REQ-017 Frame tick SHALL be high for exactly the one cycle in which xpos==0 and ypos==480.
REQ-018 start SHALL pass through a two-flop synchronizer; a rising edge of the synchronized signal forms start_evt; state SHALL change no later than 3 cycles after a start input rise held for at least 3 cycles.
REQ-019 A 6-bit frame counter SHALL be loaded on every state entry and decremented only on frame ticks.
REQ-020 IDLE: ball_run=0, flash=0; start_evt -> score=0x00, lives=LIVES_INIT, counter=SERVE_FRAMES, go SERVE.
REQ-021 SERVE: ball_run=0; on a frame tick with counter==1, ball_serve SHALL pulse for that single cycle and the FSM SHALL enter PLAY on the next cycle.
REQ-022 PLAY: ball_run=1; hit -> score increments by one in BCD (units 9 -> 0 with carry into tens); score saturates at 0x99.
REQ-023 PLAY: miss -> lives decremented by 1, counter=MISS_FRAMES, go MISS; ball_run SHALL be 0 from the next cycle onward.
REQ-024 hit and miss in the same cycle SHALL be treated as miss only; score unchanged.
REQ-025 MISS: ball_run=0, flash=1; on a frame tick with counter==1: lives==0 -> OVER, else counter=SERVE_FRAMES and go SERVE.
REQ-026 OVER: ball_run=0; flash toggles every 16 frame ticks and starts at 1 on entry; start_evt -> same re-initialisation as from IDLE, go SERVE.
REQ-027 hit and miss SHALL be ignored outside PLAY; start_evt SHALL be ignored in SERVE, PLAY and MISS.
REQ-028 lives SHALL never decrement below 0; score and lives SHALL change only per REQ-020..REQ-026.
REQ-029 ball_serve SHALL never be high in two consecutive cycles and SHALL be high only in SERVE.

Reset
REQ-030 While rst is high at a clock edge: state=IDLE, ball_run=0, ball_serve=0, flash=0, score=0x00, lives=0, counter=0, synchronizer flops=0.
REQ-031 rst SHALL override every other input in the same cycle, including mid-SERVE/PLAY/MISS; a start held high through reset SHALL NOT produce start_evt on release until it falls and rises again.

Verification
REQ-032 Reset then start pulse -> state 0->1 within 3 cycles; lives=3, score=0x00; after 60 frame ticks, ball_serve high for 1 cycle, then state=2, ball_run=1.
REQ-033 In PLAY, 10 hit pulses -> score=0x10; 99 more -> score=0x99 (saturated).
REQ-034 In PLAY, hit and miss in the same cycle -> score unchanged, lives 3->2, state=3, flash=1; after 63 frame ticks state=1.
REQ-035 Three misses from a fresh game -> lives=0, state=4 after the third MISS period; flash toggles every 16 frames; start -> state=1, score=0x00, lives=3.
REQ-036 rst asserted in PLAY with score=0x42 -> next cycle state=0, score=0x00, lives=0, ball_run=0; hit pulses in IDLE -> score stays 0x00.
REQ-037 start pulse shorter than one clock period, or start held high across reset release -> no state change.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencing controller for a VGA paddle game: start button handling,
// serve/play/miss/game-over flow, BCD score and lives bookkeeping.
module game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 63
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_run,
    output logic       ball_serve,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       flash
);

    // state  | meaning
    // IDLE   | waiting for the first start press after reset
    // SERVE  | ball parked, counting down to release
    // PLAY   | ball moving, hits score, a miss costs a life
    // MISS   | miss overlay shown, counting down
    // OVER   | no lives left, blinking overlay until start
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [5:0] SERVE_LOAD  = 6'(SERVE_FRAMES);
    localparam logic [5:0] MISS_LOAD   = 6'(MISS_FRAMES);
    localparam logic [5:0] BLINK_LOAD  = 6'd16;
    localparam logic [1:0] LIVES_LOAD  = 2'(LIVES_INIT);

    state_t     cur_st, nxt_st;
    logic [5:0] cnt, cnt_nxt;
    logic [7:0] score_nxt;
    logic [1:0] lives_nxt;
    logic       blink, blink_nxt;

    logic       sync1, sync2, sync3;
    logic       armed;
    logic [1:0] fill;
    logic       frame_tick;
    logic       start_evt;
    logic       cnt_done;

    assign frame_tick = (xpos == 10'd0) && (ypos == 10'd480);
    assign cnt_done   = frame_tick && (cnt == 6'd1);
    // armed stays low until the synchronized button has been seen low with a
    // filled chain, so a button held through reset cannot start a game.
    assign start_evt  = armed && sync2 && !sync3;
    assign state      = cur_st;

    // start synchronizer, edge history and post-reset arming
    always_ff @(posedge clk25) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
            sync3 <= sync2;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && !sync2)
                armed <= 1'b1;
        end
    end

    // state, frame counter, score, lives and blink registers
    always_ff @(posedge clk25) begin
        if (rst) begin
            cur_st <= S_IDLE;
            cnt    <= 6'd0;
            score  <= 8'h00;
            lives  <= 2'd0;
            blink  <= 1'b0;
        end else begin
            cur_st <= nxt_st;
            cnt    <= cnt_nxt;
            score  <= score_nxt;
            lives  <= lives_nxt;
            blink  <= blink_nxt;
        end
    end

    // next-state, datapath updates and outputs
    always_comb begin
        nxt_st     = cur_st;
        cnt_nxt    = (frame_tick && cnt != 6'd0) ? cnt - 6'd1 : cnt;
        score_nxt  = score;
        lives_nxt  = lives;
        blink_nxt  = blink;
        ball_run   = 1'b0;
        ball_serve = 1'b0;
        flash      = 1'b0;
        unique case (cur_st)
            S_IDLE: begin
                if (start_evt) begin
                    score_nxt = 8'h00;
                    lives_nxt = LIVES_LOAD;
                    cnt_nxt   = SERVE_LOAD;
                    nxt_st    = S_SERVE;
                end
            end
            S_SERVE: begin
                if (cnt_done) begin
                    ball_serve = 1'b1;
                    cnt_nxt    = 6'd0;
                    nxt_st     = S_PLAY;
                end
            end
            S_PLAY: begin
                ball_run = 1'b1;
                if (miss) begin
                    lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    cnt_nxt   = MISS_LOAD;
                    nxt_st    = S_MISS;
                end else if (hit && score != 8'h99) begin
                    if (score[3:0] == 4'd9)
                        score_nxt = {score[7:4] + 4'd1, 4'd0};
                    else
                        score_nxt = {score[7:4], score[3:0] + 4'd1};
                end
            end
            S_MISS: begin
                flash = 1'b1;
                if (cnt_done) begin
                    if (lives == 2'd0) begin
                        cnt_nxt   = BLINK_LOAD;
                        blink_nxt = 1'b1;
                        nxt_st    = S_OVER;
                    end else begin
                        cnt_nxt = SERVE_LOAD;
                        nxt_st  = S_SERVE;
                    end
                end
            end
            S_OVER: begin
                flash = blink;
                if (start_evt) begin
                    score_nxt = 8'h00;
                    lives_nxt = LIVES_LOAD;
                    cnt_nxt   = SERVE_LOAD;
                    nxt_st    = S_SERVE;
                end else if (cnt_done) begin
                    blink_nxt = !blink;
                    cnt_nxt   = BLINK_LOAD;
                end
            end
            default: begin
                nxt_st = S_IDLE;
            end
        endcase
    end

endmodule
